pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/isa_pkg.sv | 18 +
 rtl/pc_fetch.sv | 92 +++++++++
 2 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch unit and instruction memory users:
// fetch FSM states, the done-word encoding and the default program entry points.
package isa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    localparam logic [8:0] DONE_WORD = 9'b000_000_000;

    localparam logic [7:0] ENTRY_PRODUCT      = 8'd0;
    localparam logic [7:0] ENTRY_STRING_MATCH = 8'd25;
    localparam logic [7:0] ENTRY_CLOSEST_PAIR = 8'd44;

endpackage

// File: rtl/pc_fetch.sv
// Program counter and fetch FSM: Start loads an entry, FETCH waits one cycle, RUN fetches one word per cycle.
// Latency: 1 cycle PC->Instr; Stall freezes PC/Instr; an honoured branch flushes one slot; the done word halts.
module pc_fetch
    import isa_pkg::*;
#(
    parameter logic [7:0] ENTRY0 = ENTRY_PRODUCT,
    parameter logic [7:0] ENTRY1 = ENTRY_STRING_MATCH,
    parameter logic [7:0] ENTRY2 = ENTRY_CLOSEST_PAIR
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  ProgSel,
    output logic [7:0]  PC,
    input  logic [8:0]  iptr,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [7:0]  BranchTarget,
    output logic [8:0]  Instr,
    output logic        InstrValid,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] CycleCount
);

    fetch_state_t state;
    logic [7:0]   entry;
    logic         branch_ok;

    always_comb begin
        entry = ENTRY0;
        case (ProgSel)
            2'd1:    entry = ENTRY1;
            2'd2:    entry = ENTRY2;
            default: entry = ENTRY0;
        endcase
    end

    // A branch is only meaningful against a valid instruction that the decoder actually consumed.
    assign branch_ok = BranchTaken && InstrValid && !Stall;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            PC         <= 8'd0;
            Instr      <= 9'd0;
            InstrValid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            CycleCount <= 16'd0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (Start) begin
                        state      <= ST_FETCH;
                        PC         <= entry;
                        InstrValid <= 1'b0;
                        CycleCount <= 16'd0;
                        Busy       <= 1'b1;
                        Done       <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state      <= ST_RUN;
                    InstrValid <= 1'b0;
                end
                ST_RUN: begin
                    if (CycleCount != 16'hFFFF)
                        CycleCount <= CycleCount + 16'd1;
                    if (!Stall) begin
                        if (branch_ok) begin
                            PC         <= BranchTarget;
                            InstrValid <= 1'b0;
                        end else if (iptr == DONE_WORD) begin
                            // PC stays on the done word so software can see where it stopped.
                            state      <= ST_HALT;
                            InstrValid <= 1'b0;
                            Busy       <= 1'b0;
                            Done       <= 1'b1;
                        end else begin
                            Instr      <= iptr;
                            InstrValid <= 1'b1;
                            PC         <= PC + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
